fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of decode and drives the read-only port of the 512 KB `ram`. It holds the program counter, presents it as the RAM read address, and captures the returned 32-bit instruction word into a 2-entry buffer. The buffer is offered to decode over a valid/ready handshake. The block also handles control-flow redirects, halt, and out-of-range fetch faults.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, RAM read address, 2-entry instruction
// buffer toward decode, plus redirect, sticky halt and fetch-fault handling.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h2000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_error,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_fault,
    output logic [63:0] fault_pc
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FAULT,
        ST_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_inst_q, head_inst_d;
    logic [63:0] head_pc_q, head_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d;
    logic [63:0] tail_pc_q, tail_pc_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [63:0] fault_pc_q, fault_pc_d;

    logic pop;
    logic push;
    logic flush;

    assign mem_addr    = pc_q;
    assign inst_valid  = (count_q != 2'd0);
    assign inst        = head_inst_q;
    assign inst_pc     = head_pc_q;
    assign fetch_fault = fetch_fault_q;
    assign fault_pc    = fault_pc_q;
    assign pop         = inst_valid & inst_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_fault_d = fetch_fault_q;
        fault_pc_d    = fault_pc_q;
        push          = 1'b0;
        flush         = 1'b0;

        if (state_q != ST_HALTED && redirect_valid) begin
            flush         = 1'b1;
            pc_d          = redirect_pc;
            state_d       = ST_RUN;
            fetch_fault_d = 1'b0;
        end else if (state_q != ST_HALTED && halt) begin
            state_d = ST_HALTED;
        end else if (state_q == ST_RUN) begin
            if (mem_error || pc_q[1:0] != 2'b00) begin
                state_d       = ST_FAULT;
                fault_pc_d    = pc_q;
                fetch_fault_d = 1'b1;
            end else if (32'(count_q) < DEPTH || pop) begin
                push = 1'b1;
                pc_d = pc_q + 64'd4;
            end
        end
    end

    // Head/tail registers: head always feeds the outputs, so it is only
    // rewritten when a real entry moves into it (retains value when empty).
    always_comb begin
        count_d     = count_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;

        if (flush) begin
            count_d = 2'd0;
        end else if (push && !pop) begin
            if (count_q == 2'd0) begin
                head_inst_d = mem_data;
                head_pc_d   = pc_q;
            end else begin
                tail_inst_d = mem_data;
                tail_pc_d   = pc_q;
            end
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            if (count_q == 2'd2) begin
                head_inst_d = tail_inst_q;
                head_pc_d   = tail_pc_q;
            end
            count_d = count_q - 2'd1;
        end else if (push && pop) begin
            if (count_q == 2'd1) begin
                head_inst_d = mem_data;
                head_pc_d   = pc_q;
            end else begin
                head_inst_d = tail_inst_q;
                head_pc_d   = tail_pc_q;
                tail_inst_d = mem_data;
                tail_pc_d   = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            count_q       <= '0;
            head_inst_q   <= '0;
            head_pc_q     <= '0;
            tail_inst_q   <= '0;
            tail_pc_q     <= '0;
            fetch_fault_q <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            head_inst_q   <= head_inst_d;
            head_pc_q     <= head_pc_d;
            tail_inst_q   <= tail_inst_d;
            tail_pc_q     <= tail_pc_d;
            fetch_fault_q <= fetch_fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC   = 64'h2000;
    localparam logic [63:0] MEM_LAST = 64'h7FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_error;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready = 1'b1;
    logic        fetch_fault;
    logic [63:0] fault_pc;

    int passed = 0;
    int total  = 0;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_error(mem_error),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h2000) return 32'h11111111;
        if (a == 64'h2004) return 32'h22222222;
        return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_data  = mem_word(mem_addr);
    assign mem_error = (mem_addr > MEM_LAST);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: instruction queue, PC, halted/faulted flags.
    typedef struct {
        logic [31:0] i;
        logic [63:0] p;
    } ent_t;
    ent_t        q[$];
    logic [63:0] m_pc  = '0;
    logic        m_hlt = 1'b0;
    logic        m_flt = 1'b0;
    logic [63:0] m_fpc = '0;
    logic [31:0] sh_i  = '0;
    logic [63:0] sh_p  = '0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_pc  = RST_PC;
            m_hlt = 1'b0;
            m_flt = 1'b0;
            m_fpc = '0;
            sh_i  = '0;
            sh_p  = '0;
        end else begin
            if (q.size() > 0 && inst_ready) void'(q.pop_front());
            if (!m_hlt && redirect_valid) begin
                q.delete();
                m_pc  = redirect_pc;
                m_flt = 1'b0;
            end else if (!m_hlt && halt) begin
                m_hlt = 1'b1;
            end else if (!m_hlt && !m_flt) begin
                if (m_pc > MEM_LAST || m_pc[1:0] != 2'b00) begin
                    m_flt = 1'b1;
                    m_fpc = m_pc;
                end else if (q.size() < 2) begin
                    q.push_back('{mem_word(m_pc), m_pc});
                    m_pc = m_pc + 64'd4;
                end
            end
            if (q.size() > 0) begin
                sh_i = q[0].i;
                sh_p = q[0].p;
            end
        end
        #2;
        chk("m_valid", 64'(inst_valid), 64'(q.size() > 0));
        chk("m_inst", 64'(inst), 64'(sh_i));
        chk("m_inst_pc", inst_pc, sh_p);
        chk("m_mem_addr", mem_addr, m_pc);
        chk("m_fault", 64'(fetch_fault), 64'(m_flt));
        chk("m_fault_pc", fault_pc, m_fpc);
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic redir(input logic [63:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // reset and stream
        tick(); tick();
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_addr", mem_addr, 64'h2000);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        reset = 1'b0;
        tick();
        chk("s1_inst", 64'(inst), 64'h11111111);
        chk("s1_pc", inst_pc, 64'h2000);
        tick();
        chk("s2_inst", 64'(inst), 64'h22222222);
        chk("s2_pc", inst_pc, 64'h2004);

        // backpressure after a mid-run reset
        reset = 1'b1; inst_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("bp_valid", 64'(inst_valid), 64'd1);
        chk("bp_head", inst_pc, 64'h2000);
        chk("bp_addr", mem_addr, 64'h2008);
        inst_ready = 1'b1;
        tick(); chk("rel0", inst_pc, 64'h2004);
        tick(); chk("rel1", inst_pc, 64'h2008);
        tick(); chk("rel2", inst_pc, 64'h200C);

        // redirect with a full buffer
        redir(64'h3000);
        chk("rd_valid", 64'(inst_valid), 64'd0);
        chk("rd_addr", mem_addr, 64'h3000);
        tick();
        chk("rd_first", inst_pc, 64'h3000);
        chk("rd_vld1", 64'(inst_valid), 64'd1);
        tick();
        chk("rd_second", inst_pc, 64'h3004);

        // fault at end of memory
        redir(64'h7FFFC);
        chk("f_addr0", mem_addr, 64'h7FFFC);
        tick();
        chk("f_last_pc", inst_pc, 64'h7FFFC);
        chk("f_nofault", 64'(fetch_fault), 64'd0);
        tick();
        chk("f_fault", 64'(fetch_fault), 64'd1);
        chk("f_fault_pc", fault_pc, 64'h80000);
        chk("f_drained", 64'(inst_valid), 64'd0);
        tick();
        chk("f_nopush", 64'(inst_valid), 64'd0);
        chk("f_pc_held", mem_addr, 64'h80000);
        redir(64'h2000);
        chk("f_clear", 64'(fetch_fault), 64'd0);
        tick();
        chk("f_resume", 64'(inst), 64'h11111111);
        tick();

        // misaligned redirect
        redir(64'h2002);
        chk("mis_wait", 64'(fetch_fault), 64'd0);
        tick();
        chk("mis_fault", 64'(fetch_fault), 64'd1);
        chk("mis_pc", fault_pc, 64'h2002);

        // halt with one entry buffered
        redir(64'h2000);
        tick();
        inst_ready = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("h_head", inst_pc, 64'h2000);
        chk("h_valid", 64'(inst_valid), 64'd1);
        chk("h_addr", mem_addr, 64'h2004);
        inst_ready = 1'b1;
        tick();
        chk("h_drain", 64'(inst_valid), 64'd0);
        redir(64'h3000);
        chk("h_ign_rd", mem_addr, 64'h2004);
        tick(); tick();
        chk("h_idle", 64'(inst_valid), 64'd0);

        // reset leaves halted
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("hr_inst", 64'(inst), 64'h11111111);
        chk("hr_valid", 64'(inst_valid), 64'd1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
